// File: rtl/reg_pkg.sv
// Shared definitions for the elastic pipeline register: counter sizing and reset-value defaults.
package reg_pkg;

  localparam logic RST_BIT_DEFAULT = 1'b0;

  // A zero-width counter is illegal, so the smallest result is one bit.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One valid/data slot of the elastic pipe; accepts whenever it is empty or its successor takes its beat.
module reg_pipe_stage
  import reg_pkg::*;
#(
  parameter int unsigned           DATA_W  = 1,
  parameter logic [DATA_W-1:0]     RST_VAL = {DATA_W{RST_BIT_DEFAULT}}
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!en_i) begin
      valid_d = valid_q;
    end else if (flush_i) begin
      valid_d = 1'b0;
      data_d  = RST_VAL;
    end else if (in_valid_i && (!valid_q || out_ready_i)) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/reg_pipe.sv
// Elastic valid/ready pipeline of DEPTH stages with optional input skid slot, flush, clock enable
// and an occupancy counter.
module reg_pipe
  import reg_pkg::*;
#(
  parameter int                    DATA_W    = 1,
  parameter int                    DEPTH     = 2,
  parameter logic [DATA_W-1:0]     RST_VAL   = {DATA_W{RST_BIT_DEFAULT}},
  parameter int                    REG_READY = 0,
  localparam int unsigned          CNT_W     = clog2_safe(DEPTH + REG_READY + 1)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [CNT_W-1:0]  count_o
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("reg_pipe: DEPTH must be at least 1");
  end

  // Index 0 is the pipe input; index k+1 is the output of stage k.
  logic [DEPTH:0]             valid_s;
  logic [DEPTH:0]             ready_s;
  logic [DEPTH:0][DATA_W-1:0] data_s;
  logic                       xfer_en_s;
  logic                       acc_s;
  logic                       dlv_s;
  logic [CNT_W-1:0]           count_d, count_q;

  assign xfer_en_s = en_i & ~flush_i;

  // Ready chain evaluated from the valid flops only, so no stage output feeds back into it.
  always_comb begin
    ready_s = '0;
    ready_s[DEPTH] = m_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready_s[k] = ~valid_s[k+1] | ready_s[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    reg_pipe_stage #(
      .DATA_W  (DATA_W),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk_i       (clk_i),
      .arst_n_i    (arst_n_i),
      .en_i        (en_i),
      .flush_i     (flush_i),
      .in_valid_i  (valid_s[k]),
      .in_data_i   (data_s[k]),
      .out_valid_o (valid_s[k+1]),
      .out_data_o  (data_s[k+1]),
      .out_ready_i (ready_s[k+1])
    );
  end

  if (REG_READY != 0) begin : g_skid
    logic              skid_valid_d, skid_valid_q;
    logic [DATA_W-1:0] skid_data_d, skid_data_q;

    // A held beat always goes to stage 0 before new input; an empty slot is bypassed.
    always_comb begin
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!en_i) begin
        skid_valid_d = skid_valid_q;
      end else if (flush_i) begin
        skid_valid_d = 1'b0;
        skid_data_d  = RST_VAL;
      end else if (skid_valid_q) begin
        skid_valid_d = ~ready_s[0];
      end else if (s_valid_i && !ready_s[0]) begin
        skid_valid_d = 1'b1;
        skid_data_d  = s_data_i;
      end else begin
        skid_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        skid_valid_q <= 1'b0;
        skid_data_q  <= RST_VAL;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
      end
    end

    assign valid_s[0] = skid_valid_q | s_valid_i;
    assign data_s[0]  = skid_valid_q ? skid_data_q : s_data_i;
    assign s_ready_o  = ~skid_valid_q & xfer_en_s;
  end else begin : g_noskid
    assign valid_s[0] = s_valid_i;
    assign data_s[0]  = s_data_i;
    assign s_ready_o  = ready_s[0] & xfer_en_s;
  end

  assign acc_s = s_valid_i & s_ready_o;
  assign dlv_s = valid_s[DEPTH] & m_ready_i & xfer_en_s;

  always_comb begin
    count_d = count_q;
    if (!en_i) begin
      count_d = count_q;
    end else if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(acc_s) - CNT_W'(dlv_s);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign m_valid_o = valid_s[DEPTH] & xfer_en_s;
  assign m_data_o  = data_s[DEPTH];
  assign count_o   = count_q;

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe: three configurations (DEPTH 3 plain, DEPTH 4 plain, DEPTH 3 with
// skid slot) share control inputs and each has its own protocol-following producer and consumer.
module tb_reg_pipe;

  localparam logic [7:0] RST_V = 8'h5A;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       en = 1'b1;
  logic       flush = 1'b0;
  logic       src_on = 1'b0;
  logic       sink_on = 1'b0;
  logic       rnd_mode = 1'b0;

  logic       s_valid [3];
  logic       s_ready [3];
  logic       m_valid [3];
  logic       m_ready [3];
  logic [7:0] s_data  [3];
  logic [7:0] m_data  [3];
  logic [7:0] nxt     [3];
  logic       fire    [3];
  logic [31:0] cnt    [3];
  logic [1:0] cnt_a;
  logic [2:0] cnt_b;
  logic [2:0] cnt_c;

  int checks = 0;
  int errors = 0;
  int acc_k   [3];
  int first_k [3];

  always #5 clk = ~clk;

  reg_pipe #(.DATA_W(8), .DEPTH(3), .RST_VAL(RST_V), .REG_READY(0)) u_dut_a (
    .clk_i(clk), .arst_n_i(arst_n), .en_i(en), .flush_i(flush),
    .s_valid_i(s_valid[0]), .s_ready_o(s_ready[0]), .s_data_i(s_data[0]),
    .m_valid_o(m_valid[0]), .m_ready_i(m_ready[0]), .m_data_o(m_data[0]), .count_o(cnt_a));

  reg_pipe #(.DATA_W(8), .DEPTH(4), .RST_VAL(RST_V), .REG_READY(0)) u_dut_b (
    .clk_i(clk), .arst_n_i(arst_n), .en_i(en), .flush_i(flush),
    .s_valid_i(s_valid[1]), .s_ready_o(s_ready[1]), .s_data_i(s_data[1]),
    .m_valid_o(m_valid[1]), .m_ready_i(m_ready[1]), .m_data_o(m_data[1]), .count_o(cnt_b));

  reg_pipe #(.DATA_W(8), .DEPTH(3), .RST_VAL(RST_V), .REG_READY(1)) u_dut_c (
    .clk_i(clk), .arst_n_i(arst_n), .en_i(en), .flush_i(flush),
    .s_valid_i(s_valid[2]), .s_ready_o(s_ready[2]), .s_data_i(s_data[2]),
    .m_valid_o(m_valid[2]), .m_ready_i(m_ready[2]), .m_data_o(m_data[2]), .count_o(cnt_c));

  assign cnt[0] = 32'(cnt_a);
  assign cnt[1] = 32'(cnt_b);
  assign cnt[2] = 32'(cnt_c);

  function automatic int dep_of(input int d);
    return (d == 1) ? 4 : 3;
  endfunction

  function automatic int cap_of(input int d);
    return (d == 0) ? 3 : 4;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar d = 0; d < 3; d++) begin : g_tb
    logic [7:0] q [$];

    // Producer holds each beat until it is taken; consumer ready follows sink_on or random.
    initial begin
      s_valid[d] = 1'b0;
      s_data[d]  = 8'h00;
      m_ready[d] = 1'b0;
      nxt[d]     = 8'h01;
      forever begin
        @(posedge clk);
        #1;
        if (!s_valid[d] || fire[d]) begin
          s_valid[d] = rnd_mode ? 1'($urandom_range(0, 1)) : src_on;
          if (s_valid[d]) begin
            s_data[d] = nxt[d];
            nxt[d]    = nxt[d] + 8'd1;
          end
        end
        m_ready[d] = rnd_mode ? 1'($urandom_range(0, 1)) : sink_on;
      end
    end

    // Handshakes are decided at mid-cycle and take effect on the next rising edge.
    always @(negedge clk) begin
      if (!arst_n) begin
        q.delete();
        fire[d] <= 1'b0;
      end else begin
        check_eq($sformatf("count%0d", d), cnt[d], 32'(q.size()));
        if (!en || flush) begin
          check_eq($sformatf("s_ready_blocked%0d", d), 32'(s_ready[d]), 32'd0);
          check_eq($sformatf("m_valid_blocked%0d", d), 32'(m_valid[d]), 32'd0);
          fire[d] <= 1'b0;
          if (en) q.delete();
        end else begin
          fire[d] <= s_valid[d] & s_ready[d];
          if (q.size() == 0) begin
            check_eq($sformatf("m_valid_empty%0d", d), 32'(m_valid[d]), 32'd0);
          end else if (m_valid[d] && m_ready[d]) begin
            check_eq($sformatf("m_data%0d", d), 32'(m_data[d]), 32'(q.pop_front()));
          end
          if (s_valid[d] && s_ready[d]) q.push_back(s_data[d]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain();
    src_on   = 1'b0;
    sink_on  = 1'b1;
    rnd_mode = 1'b0;
    en       = 1'b1;
    flush    = 1'b0;
    step(3);
    for (int i = 0; i < 60 && (cnt[0] != 0 || cnt[1] != 0 || cnt[2] != 0); i++) step(1);
    for (int d = 0; d < 3; d++) check_eq($sformatf("drained%0d", d), cnt[d], 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      acc_k[d]   = 0;
      first_k[d] = 0;
    end

    // Reset state
    step(2);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst_m_valid%0d", d), 32'(m_valid[d]), 32'd0);
      check_eq($sformatf("rst_m_data%0d", d), 32'(m_data[d]), 32'(RST_V));
      check_eq($sformatf("rst_count%0d", d), cnt[d], 32'd0);
    end
    arst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) check_eq($sformatf("rst_s_ready%0d", d), 32'(s_ready[d]), 32'd1);

    // Streaming: latency from accepting edge and steady occupancy
    sink_on = 1'b1;
    src_on  = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step(1);
      for (int d = 0; d < 3; d++) begin
        if (first_k[d] == 0 && m_valid[d]) first_k[d] = k;
        if (acc_k[d] == 0 && s_valid[d] && s_ready[d]) acc_k[d] = k;
        if (k >= 8) check_eq($sformatf("steady_count%0d", d), cnt[d], 32'(dep_of(d)));
      end
    end
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("latency%0d", d), 32'(first_k[d] - acc_k[d]), 32'(dep_of(d)));
    end

    // Asynchronous reset in the middle of the stream
    #1;
    arst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("midrst_m_valid%0d", d), 32'(m_valid[d]), 32'd0);
      check_eq($sformatf("midrst_m_data%0d", d), 32'(m_data[d]), 32'(RST_V));
      check_eq($sformatf("midrst_count%0d", d), cnt[d], 32'd0);
    end
    step(2);
    arst_n = 1'b1;
    drain();

    // Backpressure fills every configuration to its capacity
    sink_on = 1'b0;
    src_on  = 1'b1;
    step(10);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("bp_count%0d", d), cnt[d], 32'(cap_of(d)));
      check_eq($sformatf("bp_s_ready%0d", d), 32'(s_ready[d]), 32'd0);
    end
    drain();

    // Bubble collapse: a lone beat runs to the end, then the rest fill in behind it
    sink_on = 1'b0;
    src_on  = 1'b1;
    step(1);
    src_on = 1'b0;
    step(3);
    for (int d = 0; d < 3; d++) check_eq($sformatf("bubble_one%0d", d), cnt[d], 32'd1);
    src_on = 1'b1;
    step(10);
    for (int d = 0; d < 3; d++) check_eq($sformatf("bubble_count%0d", d), cnt[d], 32'(cap_of(d)));
    drain();

    // Flush with two beats held and a third on offer
    for (int d = 0; d < 3; d++) nxt[d] = 8'h0A;
    sink_on = 1'b0;
    src_on  = 1'b1;
    for (int i = 0; i < 10 && cnt[0] != 2; i++) step(1);
    for (int d = 0; d < 3; d++) check_eq($sformatf("pre_flush%0d", d), cnt[d], 32'd2);
    flush = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("flush_s_ready%0d", d), 32'(s_ready[d]), 32'd0);
      check_eq($sformatf("flush_m_valid%0d", d), 32'(m_valid[d]), 32'd0);
    end
    step(1);
    flush = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("post_flush_count%0d", d), cnt[d], 32'd0);
      check_eq($sformatf("post_flush_m_valid%0d", d), 32'(m_valid[d]), 32'd0);
    end
    drain();

    // Random enable, readiness, traffic and occasional flush
    rnd_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 63) == 0);
      step(1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
